sp_loader: RTL
==============

// Module: sp_loader
// PURPOSE
//  Upstream feeder for the SP core. Receives a program/data image as a valid/ready
//  word stream from the host side and writes it into the SP SRAM write port.
//  Raises SP start, waits for SP halt, then reports completion. Replaces the
//  simulation-only memory preload with a synthesizable load path.
// PARAMETERS
//  DATA_W    32     stream word and SRAM data width
//  ADDR_W    16     SRAM address width
//  MEM_DEPTH 65536  SRAM words; used for the bounds check (<= 2**ADDR_W)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  in_valid   in   1       host word valid
//  in_data    in   DATA_W  host word: header or payload
//  in_ready   out  1       loader accepts in_data this cycle
//  mem_we     out  1       SRAM write enable (registered)
//  mem_addr   out  ADDR_W  SRAM write address (registered)
//  mem_wdata  out  DATA_W  SRAM write data (registered)
//  sp_start   out  1       start level to SP
//  sp_halt    in   1       SP finished (level or pulse)
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse after SP halt
//  err        out  1       one-cycle pulse on rejected header
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0 except in_ready=1 once
//    reset releases. Counters cleared. Mid-operation reset aborts the load;
//    mem_we and sp_start drop immediately.
//  Handshake: a word transfers on a rising edge with in_valid & in_ready.
//    in_data is sampled only on a transfer.
//  States:
//   IDLE : in_ready=1. On a transfer, in_data is the header:
//          base=in_data[31:16], count=in_data[15:0].
//          If base+count > MEM_DEPTH (17-bit compare, no wrap): err=1 for one
//          cycle; stay in IDLE.
//          Else if count==0: go to START.
//          Else latch base/count; go to LOAD.
//   LOAD : in_ready=1. Transfer k (k=0..count-1) produces mem_we=1,
//          mem_addr=base+k, mem_wdata=word in the next cycle (1-cycle latency).
//          No idle-cycle requirement: back-to-back transfers give back-to-back
//          writes. After transfer count-1, in_ready=0 in the following cycle
//          and the state is START.
//   START: in_ready=0. This is the cycle carrying the final mem_we. Go to RUN.
//   RUN  : sp_start=1, first asserted exactly 1 cycle after the final mem_we
//          (or 2 cycles after header accept when count==0).
//          Held until sp_halt is sampled high. Then go to DONE.
//   DONE : sp_start=0, done=1 for one cycle. Go to IDLE.
//  busy=1 in LOAD/START/RUN/DONE.
//  sp_halt outside RUN is ignored.
//  in_valid with in_ready=0 is held off by the host, never dropped.
//  Address arithmetic is ADDR_W bits. The bounds check guarantees no wrap;
//    base+count == MEM_DEPTH is legal (last write at MEM_DEPTH-1).
//  mem_we is never high in IDLE/RUN/DONE.
// TESTING
//  1. Header 0x0010_0003, then words A,B,C back-to-back -> writes at 0x10/0x11/0x12
//     on consecutive cycles; sp_start rises 1 cycle after the 0x12 write.
//  2. Payload with in_valid gaps of 0-3 cycles, count=5 -> exactly 5 mem_we
//     pulses at consecutive addresses; in_ready=0 from START onward.
//  3. Header 0xFFFF_0002 -> err pulse, no mem_we, still IDLE. Header 0xFFFE_0002
//     accepted; writes at 0xFFFE and 0xFFFF.
//  4. Header 0x0000_0000 -> no writes; sp_start high 2 cycles after accept.
//  5. In RUN, assert sp_halt 20 cycles later -> sp_start falls, done pulses once,
//     busy falls, in_ready=1. sp_halt pulsed in IDLE -> no effect.
//  6. reset=0 mid-LOAD after 2 of 4 words -> mem_we, sp_start, busy go 0 at once.
//     After release, a new header is accepted normally.

Source files
------------

// File: rtl/sp_loader.sv
// Streams a header plus payload words from a valid/ready host port into the SP SRAM
// write port, then starts the SP and reports completion once it halts.
module sp_loader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sp_start,
    input  logic              sp_halt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       idx_q, idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       hdr_base;
    logic [15:0]       hdr_count;
    logic [16:0]       hdr_end;

    assign xfer      = in_valid & in_ready;
    assign hdr_base  = in_data[31:16];
    assign hdr_count = in_data[15:0];
    // 17-bit sum so a header ending exactly at MEM_DEPTH is accepted and no wrap slips through
    assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_end > DEPTH_L) begin
                        err_d = 1'b1;
                    end else if (hdr_count == 16'd0) begin
                        state_d = START;
                    end else begin
                        base_d  = hdr_base[ADDR_W-1:0];
                        count_d = hdr_count;
                        idx_d   = 16'd0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + idx_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    idx_d       = idx_q + 16'd1;
                    if (idx_q == count_q - 16'd1) begin
                        state_d = START;
                    end
                end
            end
            START:   state_d = RUN;
            RUN:     if (sp_halt) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    // in_ready is held low while reset is asserted so nothing is accepted mid-reset
    assign in_ready  = reset & ((state_q == IDLE) | (state_q == LOAD));
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sp_start  = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule
